// File: rtl/co2_frame_rx.sv
// co2_frame_rx: hunts the UART byte stream for 9-byte CO2 sensor response
// frames (FF, cmd, ppm_hi, ppm_lo, temp, 3 x don't care, checksum). It checks
// the command byte and the two's-complement checksum. On a good frame it
// latches the concentration and the raw temperature byte.
//
// Ports:
//   clk, rst          master clock, synchronous active-high reset
//   received, rx_byte one-cycle byte strobe and data from the UART receiver
//   recv_error        one-cycle UART framing error strobe
//   co2_ppm, temp_raw last good frame payload
//   frame_valid       one-cycle pulse when a good frame is latched
//   frame_error       one-cycle pulse when a frame is aborted
//   error_count       aborted frames, saturating at 255
//   busy              parser is inside a frame
module co2_frame_rx #(
  parameter logic [7:0]  EXPECT_CMD     = 8'h86,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  output logic [15:0] co2_ppm,
  output logic [7:0]  temp_raw,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [7:0]  error_count,
  output logic        busy
);

  localparam logic [7:0] START_BYTE = 8'hFF;

  typedef enum logic [1:0] {HUNT, BODY, CHECK} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  sum;
  logic [15:0] timer;
  logic [7:0]  ppm_hi;
  logic [7:0]  ppm_lo;
  logic [7:0]  temp_hold;

  logic       abort_c;
  logic [7:0] expected_chk_c;

  // Every abort cause in one place; recv_error outranks a same-cycle byte,
  // and a byte outranks a same-cycle timer expiry.
  always_comb begin
    expected_chk_c = 8'(8'h00 - sum);
    abort_c        = 1'b0;
    if (state != HUNT) begin
      if (recv_error) begin
        abort_c = 1'b1;
      end else if (received) begin
        if (state == BODY && idx == 3'd1 && rx_byte != START_BYTE && rx_byte != EXPECT_CMD)
          abort_c = 1'b1;
        else if (state == CHECK && rx_byte != expected_chk_c)
          abort_c = 1'b1;
      end else if (timer == 16'(TIMEOUT_CYCLES - 16'd1)) begin
        abort_c = 1'b1;
      end
    end
  end

  // Parser FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      idx         <= 3'd0;
      sum         <= 8'd0;
      timer       <= 16'd0;
      ppm_hi      <= 8'd0;
      ppm_lo      <= 8'd0;
      temp_hold   <= 8'd0;
      co2_ppm     <= 16'd0;
      temp_raw    <= 8'd0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      error_count <= 8'd0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (abort_c) begin
        frame_error <= 1'b1;
        if (error_count != 8'hFF)
          error_count <= 8'(error_count + 8'd1);
        state <= HUNT;
        busy  <= 1'b0;
        timer <= 16'd0;
      end else begin
        case (state)
          HUNT: begin
            timer <= 16'd0;
            if (received && !recv_error && rx_byte == START_BYTE) begin
              sum   <= 8'd0;
              idx   <= 3'd1;
              state <= BODY;
              busy  <= 1'b1;
            end
          end
          BODY: begin
            if (received) begin
              timer <= 16'd0;
              if (idx == 3'd1 && rx_byte == START_BYTE) begin
                // Repeated start byte: resynchronise on it.
                sum <= 8'd0;
              end else begin
                sum <= 8'(sum + rx_byte);
                case (idx)
                  3'd2:    ppm_hi    <= rx_byte;
                  3'd3:    ppm_lo    <= rx_byte;
                  3'd4:    temp_hold <= rx_byte;
                  default: ;
                endcase
                if (idx == 3'd7)
                  state <= CHECK;
                else
                  idx <= 3'(idx + 3'd1);
              end
            end else begin
              timer <= 16'(timer + 16'd1);
            end
          end
          CHECK: begin
            if (received) begin
              // Checksum already known good here; mismatches go via abort_c.
              timer       <= 16'd0;
              co2_ppm     <= {ppm_hi, ppm_lo};
              temp_raw    <= temp_hold;
              frame_valid <= 1'b1;
              state       <= HUNT;
              busy        <= 1'b0;
            end else begin
              timer <= 16'(timer + 16'd1);
            end
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_co2_frame_rx.sv
// tb_co2_frame_rx: directed self-checking bench for co2_frame_rx. Expected
// frame events (kind, payload, count, cycle) are queued when the triggering
// stimulus is driven, then popped and compared when the DUT pulses.
module tb_co2_frame_rx;

  localparam int unsigned T = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;
  logic [15:0] co2_ppm;
  logic [7:0]  temp_raw;
  logic        frame_valid;
  logic        frame_error;
  logic [7:0]  error_count;
  logic        busy;

  co2_frame_rx dut (
    .clk         (clk),
    .rst         (rst),
    .received    (received),
    .rx_byte     (rx_byte),
    .recv_error  (recv_error),
    .co2_ppm     (co2_ppm),
    .temp_raw    (temp_raw),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .error_count (error_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          valid;
    logic [15:0] ppm;
    logic [7:0]  temp;
    logic [7:0]  cnt;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [15:0] exp_ppm  = 16'd0;
  logic [7:0]  exp_temp = 8'd0;
  logic [7:0]  exp_cnt  = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One input cycle: values driven just after the edge, sampled at the next.
  task automatic put(input logic r, input logic [7:0] b, input logic err);
    @(posedge clk);
    #1;
    received   = r;
    rx_byte    = b;
    recv_error = err;
  endtask

  task automatic expect_ev(input bit v, input int at);
    exp_t x;
    if (!v && exp_cnt != 8'hFF) exp_cnt = 8'(exp_cnt + 8'd1);
    x.valid = v;
    x.ppm   = exp_ppm;
    x.temp  = exp_temp;
    x.cnt   = exp_cnt;
    x.at    = at;
    q.push_back(x);
  endtask

  task automatic good_frame(input logic [15:0] ppm, input logic [7:0] t);
    logic [7:0] s;
    s = 8'(8'h86 + ppm[15:8] + ppm[7:0] + t);
    put(1'b1, 8'hFF, 1'b0);
    put(1'b1, 8'h86, 1'b0);
    put(1'b1, ppm[15:8], 1'b0);
    put(1'b1, ppm[7:0], 1'b0);
    put(1'b1, t, 1'b0);
    for (int i = 0; i < 3; i++) put(1'b1, 8'h00, 1'b0);
    put(1'b1, 8'(8'h00 - s), 1'b0);
    exp_ppm  = ppm;
    exp_temp = t;
    expect_ev(1'b1, cyc + 1);
    put(1'b0, 8'h00, 1'b0);
  endtask

  // Scoreboard side: every output pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && (frame_valid === 1'b1 || frame_error === 1'b1)) begin
      if (q.size() == 0) begin
        check("unexpected_event", {30'd0, frame_valid, frame_error}, 32'd0);
      end else begin
        e = q.pop_front();
        check("event_kind", {30'd0, frame_valid, frame_error}, e.valid ? 32'd2 : 32'd1);
        check("event_cycle", 32'(cyc), 32'(e.at));
        check("co2_ppm", {16'd0, co2_ppm}, {16'd0, e.ppm});
        check("temp_raw", {24'd0, temp_raw}, {24'd0, e.temp});
        check("error_count", {24'd0, error_count}, {24'd0, e.cnt});
        check("busy_at_event", {31'd0, busy}, 32'd0);
      end
    end
  end

  logic [7:0] f1 [9]  = '{8'hFF, 8'h86, 8'h01, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE9};
  logic [7:0] f3 [12] = '{8'h12, 8'h34, 8'hFF, 8'hFF, 8'h86, 8'h02, 8'h58, 8'h40,
                          8'h00, 8'h00, 8'h00, 8'hE0};
  int n_last;

  initial begin
    rst = 1'b1; received = 1'b0; rx_byte = 8'h00; recv_error = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_co2_ppm", {16'd0, co2_ppm}, 32'd0);
    check("rst_temp_raw", {24'd0, temp_raw}, 32'd0);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_error_count", {24'd0, error_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Good frame: 400 ppm.
    for (int i = 0; i < 9; i++) begin
      put(1'b1, f1[i], 1'b0);
      if (i == 1) begin
        @(negedge clk);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
      end
    end
    exp_ppm = 16'd400; exp_temp = 8'h00;
    expect_ev(1'b1, cyc + 1);
    put(1'b0, 8'h00, 1'b0);

    // Same frame with a bad checksum.
    for (int i = 0; i < 8; i++) put(1'b1, f1[i], 1'b0);
    put(1'b1, 8'hE8, 1'b0);
    expect_ev(1'b0, cyc + 1);
    put(1'b0, 8'h00, 1'b0);

    // Garbage, then a doubled start byte, then a good frame (600 ppm).
    for (int i = 0; i < 12; i++) put(1'b1, f3[i], 1'b0);
    exp_ppm = 16'd600; exp_temp = 8'h40;
    expect_ev(1'b1, cyc + 1);
    put(1'b0, 8'h00, 1'b0);

    // Gap timeout after FF 86 01.
    put(1'b1, 8'hFF, 1'b0);
    put(1'b1, 8'h86, 1'b0);
    put(1'b1, 8'h01, 1'b0);
    n_last = cyc;
    expect_ev(1'b0, n_last + T + 1);
    put(1'b0, 8'h00, 1'b0);
    repeat (T + 2) @(posedge clk);
    @(negedge clk);
    check("busy_after_timeout", {31'd0, busy}, 32'd0);
    good_frame(16'd400, 8'h00);

    // Byte arriving on the cycle the timer would expire wins.
    put(1'b1, 8'hFF, 1'b0);
    put(1'b1, 8'h86, 1'b0);
    for (int i = 0; i < T - 1; i++) put(1'b0, 8'h00, 1'b0);
    for (int i = 2; i < 9; i++) put(1'b1, f1[i], 1'b0);
    exp_ppm = 16'd400; exp_temp = 8'h00;
    expect_ev(1'b1, cyc + 1);
    put(1'b0, 8'h00, 1'b0);

    // recv_error after byte 5, coinciding with a byte that must be dropped.
    for (int i = 0; i < 6; i++) put(1'b1, f1[i], 1'b0);
    put(1'b1, 8'h00, 1'b1);
    expect_ev(1'b0, cyc + 1);
    put(1'b0, 8'h00, 1'b0);

    // recv_error while hunting is ignored.
    put(1'b0, 8'h00, 1'b1);
    put(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hunt_recv_error_count", {24'd0, error_count}, {24'd0, exp_cnt});

    // Back-to-back good frame with a different payload.
    good_frame(16'h1234, 8'h5A);

    // 256 command-mismatch frames saturate the counter.
    for (int i = 0; i < 256; i++) begin
      put(1'b1, 8'hFF, 1'b0);
      put(1'b1, 8'h00, 1'b0);
      expect_ev(1'b0, cyc + 1);
    end
    put(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("count_saturated", {24'd0, error_count}, 32'd255);

    // Reset after byte 4 of a frame; the tail is discarded silently.
    for (int i = 0; i < 5; i++) put(1'b1, f1[i], 1'b0);
    @(posedge clk);
    #1 rst = 1'b1; received = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_ppm = 16'd0; exp_temp = 8'd0; exp_cnt = 8'd0;
    @(negedge clk);
    check("midrst_co2_ppm", {16'd0, co2_ppm}, 32'd0);
    check("midrst_temp_raw", {24'd0, temp_raw}, 32'd0);
    check("midrst_error_count", {24'd0, error_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    for (int i = 5; i < 9; i++) put(1'b1, f1[i], 1'b0);
    put(1'b0, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("tail_busy", {31'd0, busy}, 32'd0);
    check("tail_error_count", {24'd0, error_count}, 32'd0);

    // A good frame after reset is still accepted.
    good_frame(16'd600, 8'h40);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pending_events", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
